// File: rtl/ece423_mul_pkg.sv
// Shared definitions for the CPU multiply sequencer: op encodings, FSM states, accumulator width.
package ece423_mul_pkg;

    localparam logic [1:0] MUL_OP_MUL    = 2'b00;
    localparam logic [1:0] MUL_OP_MULXUU = 2'b01;
    localparam logic [1:0] MUL_OP_MULXSU = 2'b10;
    localparam logic [1:0] MUL_OP_MULXSS = 2'b11;

    localparam int MUL_ACC_W = 49;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PASS1 = 3'd1,
        ST_SUM1  = 3'd2,
        ST_PASS2 = 3'd3,
        ST_SUM2  = 3'd4
    } mul_state_t;

endpackage

// File: rtl/ece423_mul_partial_sum.sv
// Combines the three 16x16 partial products into the 49-bit accumulator; purely combinational.
// p1 + ((p2 + p3) << 16) cannot exceed 49 bits for 16-bit slices.
module ece423_mul_partial_sum
    import ece423_mul_pkg::*;
(
    input  logic [31:0]          p1,
    input  logic [31:0]          p2,
    input  logic [31:0]          p3,
    output logic [MUL_ACC_W-1:0] acc
);

    logic [32:0] mid;

    assign mid = {1'b0, p2} + {1'b0, p3};
    assign acc = {17'b0, p1} + {mid, 16'b0};

endmodule

// File: rtl/ece423_qsys_cpu_1_cpu_mul_seq.sv
// Multiply sequencer: drives a registered 16x16 cell, MUL in 3 cycles, MULX* (high word) in 5.
// busy blocks new requests; result holds until the next done pulse.
module ece423_qsys_cpu_1_cpu_mul_seq
    import ece423_mul_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic [31:0] cell_src1,
    output logic [31:0] cell_src2,
    output logic        cell_en,
    input  logic [31:0] cell_p1,
    input  logic [31:0] cell_p2,
    input  logic [31:0] cell_p3,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    mul_state_t             state_q, state_d;
    logic [31:0]            a_q, a_d;
    logic [31:0]            b_q, b_d;
    logic [1:0]             op_q, op_d;
    logic [MUL_ACC_W-1:0]   acc_q, acc_d;
    logic [31:0]            result_q, result_d;
    logic                   done_q, done_d;

    logic [MUL_ACC_W-1:0]   acc_w;
    logic [31:0]            hu;
    logic [31:0]            corr_b;
    logic [31:0]            corr_a;

    ece423_mul_partial_sum u_psum (
        .p1  (cell_p1),
        .p2  (cell_p2),
        .p3  (cell_p3),
        .acc (acc_w)
    );

    // High word of (hi*hi << 32) + acc; the low 32 bits of acc only feed carries into it.
    assign hu = 32'(({cell_p1, 32'b0} + {15'b0, acc_q}) >> 32);

    // Signed high word = unsigned high word minus the two's-complement correction terms.
    assign corr_b = ((op_q == MUL_OP_MULXSU || op_q == MUL_OP_MULXSS) && a_q[31]) ? b_q : 32'h0;
    assign corr_a = ((op_q == MUL_OP_MULXSS) && b_q[31]) ? a_q : 32'h0;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        acc_d     = acc_q;
        result_d  = result_q;
        done_d    = 1'b0;
        cell_en   = 1'b0;
        cell_src1 = a_q;
        cell_src2 = b_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = src1;
                    b_d     = src2;
                    op_d    = op;
                    state_d = ST_PASS1;
                end
            end
            ST_PASS1: begin
                cell_en = 1'b1;
                state_d = ST_SUM1;
            end
            ST_SUM1: begin
                acc_d = acc_w;
                if (op_q == MUL_OP_MUL) begin
                    result_d = acc_w[31:0];
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    state_d  = ST_PASS2;
                end
            end
            ST_PASS2: begin
                cell_en   = 1'b1;
                cell_src1 = {16'h0, a_q[31:16]};
                cell_src2 = {16'h0, b_q[31:16]};
                state_d   = ST_SUM2;
            end
            ST_SUM2: begin
                result_d = hu - corr_b - corr_a;
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            a_q      <= 32'h0;
            b_q      <= 32'h0;
            op_q     <= MUL_OP_MUL;
            acc_q    <= '0;
            result_q <= 32'h0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_ece423_qsys_cpu_1_cpu_mul_seq.sv
// Directed bench for the multiply sequencer paired with a 1-cycle registered 16x16 cell model.
module tb_ece423_qsys_cpu_1_cpu_mul_seq;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] cell_src1;
    logic [31:0] cell_src2;
    logic        cell_en;
    logic [31:0] cell_p1;
    logic [31:0] cell_p2;
    logic [31:0] cell_p3;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int tests_run = 0;
    int tests_failed = 0;

    ece423_qsys_cpu_1_cpu_mul_seq dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .op        (op),
        .src1      (src1),
        .src2      (src2),
        .cell_src1 (cell_src1),
        .cell_src2 (cell_src2),
        .cell_en   (cell_en),
        .cell_p1   (cell_p1),
        .cell_p2   (cell_p2),
        .cell_p3   (cell_p3),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cell_p1 = 32'h0;
        cell_p2 = 32'h0;
        cell_p3 = 32'h0;
    end

    always @(posedge clk) begin
        if (cell_en) begin
            cell_p1 <= cell_src1[15:0]  * cell_src2[15:0];
            cell_p2 <= cell_src1[15:0]  * cell_src2[31:16];
            cell_p3 <= cell_src1[31:16] * cell_src2[15:0];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; launches a request and follows it until done or a cycle budget expires.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit poke,
                          output int lat, output int npulse, output int busy_err,
                          output logic [31:0] s1a, output logic [31:0] s1b,
                          output logic [31:0] s2b);
        op = o; src1 = x; src2 = y; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0; npulse = 0; busy_err = 0;
        s1a = 32'hx; s1b = 32'hx; s2b = 32'hx;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (cell_en) begin
                npulse++;
                if (npulse == 1) s1a = cell_src1;
                s1b = cell_src1;
                s2b = cell_src2;
            end
            if (done) begin
                lat = n;
                if (busy) busy_err++;
                break;
            end
            if (!busy) busy_err++;
            if (poke && n == 1) begin
                start = 1'b1; op = 2'b00; src1 = 32'h12345678; src2 = 32'h00000003;
            end
            if (poke && n == 2) start = 1'b0;
        end
    endtask

    int          lat, np, berr, ndone;
    logic [31:0] s1a, s1b, s2b, held;

    initial begin
        reset_n = 1'b0; start = 1'b0; op = 2'b00; src1 = 32'h0; src2 = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy",  {31'b0, busy},    32'h0);
        check("rst_done",  {31'b0, done},    32'h0);
        check("rst_result", result,          32'h0);
        check("rst_cell_en", {31'b0, cell_en}, 32'h0);
        check("rst_src1",  cell_src1,        32'h0);
        check("rst_src2",  cell_src2,        32'h0);
        reset_n = 1'b1;

        run_op(2'b00, 32'h00010003, 32'h00020005, 1'b0, lat, np, berr, s1a, s1b, s2b);
        check("mul_result", result, 32'h000B000F);
        check("mul_lat", lat, 3);
        check("mul_pulses", np, 1);
        check("mul_busy", berr, 0);
        check("mul_pass1_src1", s1a, 32'h00010003);
        held = result;
        @(negedge clk);
        check("mul_done_width", {31'b0, done}, 32'h0);
        check("mul_result_hold", result, held);

        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, lat, np, berr, s1a, s1b, s2b);
        check("uu_ff_result", result, 32'hFFFFFFFE);
        check("uu_ff_lat", lat, 5);
        check("uu_ff_pulses", np, 2);
        check("uu_ff_busy", berr, 0);
        check("uu_ff_pass2_src1", s1b, 32'h0000FFFF);
        check("uu_ff_pass2_src2", s2b, 32'h0000FFFF);

        @(negedge clk);
        run_op(2'b11, 32'hFFFFFFFF, 32'h00000002, 1'b0, lat, np, berr, s1a, s1b, s2b);
        check("ss_m1x2_result", result, 32'hFFFFFFFF);
        check("ss_m1x2_lat", lat, 5);
        @(negedge clk);
        run_op(2'b11, 32'h80000000, 32'h80000000, 1'b0, lat, np, berr, s1a, s1b, s2b);
        check("ss_min_result", result, 32'h40000000);
        @(negedge clk);
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, lat, np, berr, s1a, s1b, s2b);
        check("su_result", result, 32'h80000000);
        check("su_lat", lat, 5);
        @(negedge clk);
        run_op(2'b01, 32'h80000000, 32'hFFFFFFFF, 1'b0, lat, np, berr, s1a, s1b, s2b);
        check("uu_result", result, 32'h7FFFFFFF);

        // Start while busy is ignored; start in the done cycle is taken immediately.
        @(negedge clk);
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, lat, np, berr, s1a, s1b, s2b);
        check("ignore_result", result, 32'hFFFFFFFE);
        check("ignore_lat", lat, 5);
        check("ignore_pulses", np, 2);
        run_op(2'b00, 32'h00010003, 32'h00020005, 1'b0, lat, np, berr, s1a, s1b, s2b);
        check("b2b_lat", lat, 3);
        check("b2b_result", result, 32'h000B000F);
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, lat, np, berr, s1a, s1b, s2b);
        check("b2b_x_lat", lat, 5);
        check("b2b_x_result", result, 32'hFFFFFFFE);

        // Reset while in PASS2 drops the request.
        @(negedge clk);
        op = 2'b01; src1 = 32'h80000000; src2 = 32'hFFFFFFFF; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        check("pass2_cell_en", {31'b0, cell_en}, 32'h1);
        check("pass2_src1", cell_src1, 32'h00008000);
        reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", {31'b0, busy}, 32'h0);
        check("mid_rst_done", {31'b0, done}, 32'h0);
        check("mid_rst_result", result, 32'h0);
        ndone = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("mid_rst_no_done", ndone, 0);
        run_op(2'b00, 32'h00000007, 32'h00000006, 1'b0, lat, np, berr, s1a, s1b, s2b);
        check("post_rst_result", result, 32'h0000002A);
        check("post_rst_lat", lat, 3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
